// File: rtl/k10_mul_div_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : k10_mul_div_iter_pkg
//  Description : Shared types and opcode decode helpers for the K10 M-unit.
//  Revision    : 1.0 - initial iterative multiply/divide release
// ============================================================================
package k10_mul_div_iter_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE  = 3'd0,
        MD_PREP  = 3'd1,
        MD_CALC  = 3'd2,
        MD_FIXUP = 3'd3,
        MD_DONE  = 3'd4
    } md_state_e;

    function automatic logic md_is_signed_a(md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_is_signed_b(md_op_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_is_div(md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic md_is_rem(md_op_e op);
        return (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic md_is_high(md_op_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_MULHU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/k10_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : k10_div_step
//  Description : DIV_BITS unrolled restoring-division steps (combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
module k10_div_step #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN-1:0] w_r;
    logic [XLEN-1:0] w_q;
    logic [XLEN:0]   w_sh;
    logic [XLEN:0]   w_diff;

    // Dividend bits leave the top of w_q while quotient bits enter at the bottom.
    always_comb begin
        w_r    = i_rem;
        w_q    = i_quo;
        w_sh   = '0;
        w_diff = '0;
        for (int k = 0; k < DIV_BITS; k++) begin
            w_sh   = {w_r, w_q[XLEN-1]};
            w_diff = w_sh - {1'b0, i_div};
            w_r    = w_diff[XLEN] ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            w_q    = {w_q[XLEN-2:0], ~w_diff[XLEN]};
        end
    end

    assign o_rem = w_r;
    assign o_quo = w_q;

endmodule
`default_nettype wire

// File: rtl/k10_mul_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : k10_mul_div_iter
//  Description : Iterative RV32M/RV64M multiply/divide with valid/ready and kill.
//  Revision    : 1.0 - initial release
// ============================================================================
module k10_mul_div_iter
    import k10_mul_div_iter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MUL_BITS = 4,
    parameter int DIV_BITS = 1,
    parameter int TAG_W    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [2:0]       i_req_op,
    input  logic [XLEN-1:0]  i_req_a,
    input  logic [XLEN-1:0]  i_req_b,
    input  logic [TAG_W-1:0] i_req_tag,
    input  logic             i_kill,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [XLEN-1:0]  o_rsp_result,
    output logic [TAG_W-1:0] o_rsp_tag,
    output logic             o_busy
);

    localparam int              c_mul_n   = XLEN / MUL_BITS;
    localparam int              c_div_n   = XLEN / DIV_BITS;
    localparam int              c_cnt_w   = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_min_int = {1'b1, {(XLEN-1){1'b0}}};

    if ((XLEN % MUL_BITS) != 0) begin : g_chk_mul
        $error("MUL_BITS must divide XLEN");
    end
    if ((XLEN % DIV_BITS) != 0) begin : g_chk_div
        $error("DIV_BITS must divide XLEN");
    end

    md_state_e          r_state, w_state_nxt;
    md_op_e             w_req_op, r_op;
    logic               w_accept;
    logic [XLEN-1:0]    r_x;      // multiplier / dividend-quotient
    logic [2*XLEN-1:0]  r_y;      // multiplicand / divisor
    logic [2*XLEN-1:0]  r_acc;    // product / partial remainder
    logic               r_neg;
    logic [c_cnt_w-1:0] r_cnt;
    logic [XLEN-1:0]    r_result;
    logic [TAG_W-1:0]   r_tag;

    assign w_req_op     = md_op_e'(i_req_op);
    assign o_rsp_result = r_result;
    assign o_rsp_tag    = r_tag;

    // Divide-by-zero and signed overflow finish straight from IDLE.
    logic            w_b_zero, w_special;
    logic [XLEN-1:0] w_special_res;
    assign w_b_zero  = (i_req_b == '0);
    assign w_special = md_is_div(w_req_op) &&
                       (w_b_zero || (md_is_signed_a(w_req_op) && (i_req_a == c_min_int) && (&i_req_b)));
    assign w_special_res = w_b_zero ? (md_is_rem(w_req_op) ? i_req_a : '1)
                                    : (md_is_rem(w_req_op) ? '0 : c_min_int);

    logic            w_a_neg, w_b_neg, w_neg;
    logic [XLEN-1:0] w_a_mag, w_b_mag;
    assign w_a_neg = md_is_signed_a(r_op) & r_x[XLEN-1];
    assign w_b_neg = md_is_signed_b(r_op) & r_y[XLEN-1];
    assign w_a_mag = w_a_neg ? -r_x : r_x;
    assign w_b_mag = w_b_neg ? -r_y[XLEN-1:0] : r_y[XLEN-1:0];
    assign w_neg   = md_is_rem(r_op) ? w_a_neg : (w_a_neg ^ w_b_neg);

    logic [2*XLEN-1:0] w_mul_add;
    always_comb begin
        w_mul_add = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (r_x[j]) w_mul_add = w_mul_add + (r_y << j);
        end
    end

    logic [XLEN-1:0] w_rem_nxt, w_quo_nxt;
    k10_div_step #(.XLEN(XLEN), .DIV_BITS(DIV_BITS)) u_div_step (
        .i_rem (r_acc[XLEN-1:0]),
        .i_quo (r_x),
        .i_div (r_y[XLEN-1:0]),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_qr, w_qr_s, w_fix_res;
    assign w_prod    = r_neg ? -r_acc : r_acc;
    assign w_qr      = md_is_rem(r_op) ? r_acc[XLEN-1:0] : r_x;
    assign w_qr_s    = r_neg ? -w_qr : w_qr;
    assign w_fix_res = md_is_div(r_op)  ? w_qr_s :
                       md_is_high(r_op) ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= MD_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        w_accept    = 1'b0;
        o_busy      = (r_state != MD_IDLE);
        case (r_state)
            MD_IDLE: begin
                o_req_ready = ~i_kill;
                w_accept    = i_req_valid & ~i_kill;
                if (w_accept) w_state_nxt = w_special ? MD_DONE : MD_PREP;
            end
            MD_PREP:  w_state_nxt = MD_CALC;
            MD_CALC:  if (r_cnt == '0) w_state_nxt = MD_FIXUP;
            MD_FIXUP: w_state_nxt = MD_DONE;
            MD_DONE: begin
                o_rsp_valid = ~i_kill;
                if (i_rsp_ready) w_state_nxt = MD_IDLE;
            end
            default:  w_state_nxt = MD_IDLE;
        endcase
        if (i_kill) w_state_nxt = MD_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op     <= MD_MUL;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_tag    <= '0;
        end else begin
            case (r_state)
                MD_IDLE: if (w_accept) begin
                    r_op  <= w_req_op;
                    r_tag <= i_req_tag;
                    r_x   <= i_req_a;
                    r_y   <= {{XLEN{1'b0}}, i_req_b};
                    if (w_special) r_result <= w_special_res;
                end
                MD_PREP: begin
                    r_neg <= w_neg;
                    r_acc <= '0;
                    if (md_is_div(r_op)) begin
                        r_x   <= w_a_mag;
                        r_y   <= {{XLEN{1'b0}}, w_b_mag};
                        r_cnt <= c_cnt_w'(c_div_n - 1);
                    end else begin
                        r_x   <= w_b_mag;
                        r_y   <= {{XLEN{1'b0}}, w_a_mag};
                        r_cnt <= c_cnt_w'(c_mul_n - 1);
                    end
                end
                MD_CALC: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (md_is_div(r_op)) begin
                        r_acc <= {{XLEN{1'b0}}, w_rem_nxt};
                        r_x   <= w_quo_nxt;
                    end else begin
                        r_acc <= r_acc + w_mul_add;
                        r_y   <= r_y << MUL_BITS;
                        r_x   <= r_x >> MUL_BITS;
                    end
                end
                MD_FIXUP: r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_accept) assert (!$isunknown(i_req_op));
    end

endmodule
`default_nettype wire

// File: tb/tb_k10_mul_div_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k10_mul_div_iter
//  Description : Scoreboard bench for k10_mul_div_iter with directed vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_k10_mul_div_iter;
    import k10_mul_div_iter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_tag = '0;
    logic        kill = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_tag;
    logic        busy;

    k10_mul_div_iter #(.XLEN(32), .MUL_BITS(4), .DIV_BITS(1), .TAG_W(5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_op     (req_op),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .i_req_tag    (req_tag),
        .i_kill       (kill),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_result (rsp_result),
        .o_rsp_tag    (rsp_tag),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          acc;
        int          lat;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   mon_first = -1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard on every response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid && mon_first < 0) mon_first = cyc;
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: actual result 0x%0h tag %0d required no response", rsp_result, rsp_tag);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_result"}, 64'(rsp_result), 64'(e.res));
                    chk({e.name, "_tag"}, 64'(rsp_tag), 64'(e.tag));
                    chk({e.name, "_latency"}, 64'(mon_first - e.acc), 64'(e.lat));
                end
                mon_first = -1;
            end
            if (!rsp_valid) mon_first = -1;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res, input int exp_lat,
                         input bit push, input string name);
        int   waited = 0;
        bit   ok = 1'b0;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        while (!ok && waited < 100) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else waited++;
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_accept: actual req_ready 0 required 1 within 100 cycles", name);
        end else if (push) begin
            e.res  = exp_res;
            e.tag  = tag;
            e.acc  = cyc;
            e.lat  = exp_lat;
            e.name = name;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_chk++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL %s_idle: actual busy %0d pending %0d required idle", name, busy, sb.size());
        end
    endtask

    task automatic run(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp_res, input int exp_lat,
                       input string name);
        issue(op, a, b, tag, exp_res, exp_lat, 1'b1, name);
        wait_idle(name);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_result", 64'(rsp_result), 64'd0);
        chk("reset_tag", 64'(rsp_tag), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);

        run(MD_MUL,    32'd7,         32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 11, "mul");
        run(MD_MULH,   32'h80000000,  32'h80000000, 5'd2,  32'h40000000, 11, "mulh");
        run(MD_MULHSU, 32'hFFFFFFFF,  32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF, 11, "mulhsu");
        run(MD_MULHU,  32'hFFFFFFFF,  32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 11, "mulhu");
        run(MD_DIV,    32'hFFFFFFEC,  32'd3,        5'd5,  32'hFFFFFFFA, 35, "div");
        run(MD_REM,    32'hFFFFFFEC,  32'd3,        5'd6,  32'hFFFFFFFE, 35, "rem");
        run(MD_DIVU,   32'd100,       32'd7,        5'd7,  32'd14,       35, "divu");
        run(MD_REMU,   32'd100,       32'd7,        5'd8,  32'd2,        35, "remu");
        run(MD_DIV,    32'd5,         32'd0,        5'd9,  32'hFFFFFFFF, 1,  "div_by0");
        run(MD_REM,    32'd5,         32'd0,        5'd10, 32'd5,        1,  "rem_by0");
        run(MD_DIVU,   32'd100,       32'd0,        5'd11, 32'hFFFFFFFF, 1,  "divu_by0");
        run(MD_REMU,   32'd100,       32'd0,        5'd12, 32'd100,      1,  "remu_by0");
        run(MD_DIV,    32'h80000000,  32'hFFFFFFFF, 5'd13, 32'h80000000, 1,  "div_ovf");
        run(MD_REM,    32'h80000000,  32'hFFFFFFFF, 5'd14, 32'd0,        1,  "rem_ovf");

        // Backpressure: response held in DONE for 10 cycles.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        issue(MD_MUL, 32'd6, 32'd7, 5'd9, 32'd42, 11, 1'b1, "bp");
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 64'(rsp_valid), 64'd1);
            chk("bp_hold_result", 64'(rsp_result), 64'd42);
            chk("bp_hold_tag", 64'(rsp_tag), 64'd9);
            chk("bp_hold_req_ready", 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_release_req_ready", 64'(req_ready), 64'd1);
        wait_idle("bp");

        // Kill during the fifth CALC cycle of a DIV: no response may follow.
        issue(MD_DIV, 32'd1000, 32'd7, 5'd3, 32'd0, 0, 1'b0, "kill_div");
        repeat (5) @(posedge clk);
        #1;
        kill = 1'b1;
        @(negedge clk);
        chk("kill_busy_before", 64'(busy), 64'd1);
        chk("kill_req_ready_masked", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_idle_busy", 64'(busy), 64'd0);
        chk("kill_idle_req_ready", 64'(req_ready), 64'd1);
        repeat (40) @(negedge clk);
        run(MD_MUL, 32'd3, 32'd5, 5'd4, 32'd15, 11, "post_kill_mul");

        // Asynchronous reset in the middle of a divide aborts it silently.
        issue(MD_DIVU, 32'd1000, 32'd3, 5'd20, 32'd0, 0, 1'b0, "rst_div");
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_result", 64'(rsp_result), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run(MD_DIVU, 32'd1000, 32'd3, 5'd21, 32'd333, 35, "post_rst_divu");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
